// File: rtl/bus_initiator.sv
// Strobed peripheral bus master: one request becomes setup, strobe and hold phases, then a one-clock response.
// Latency SETUP+STROBE+HOLD+1 clocks from acceptance to rsp_valid; req_ready is high only in IDLE.
module bus_initiator #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] address_bus,
    output logic        write_strobe_b,
    output logic        read_strobe_b,
    inout  wire  [7:0]  data_bus,
    output logic        data_oe
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       cnt_zero;
    logic       accept;
    logic       wr_q;
    logic [7:0] wdata_q;
    logic [7:0] cap_q;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign cnt_zero  = (cnt == 8'd0);
    assign data_bus  = data_oe ? wdata_q : 'z;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_nxt = STROBE;
                    cnt_nxt   = STROBE_LOAD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            STROBE: begin
                if (cnt_zero) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            wr_q           <= 1'b0;
            wdata_q        <= 8'h00;
            cap_q          <= 8'h00;
            address_bus    <= 16'h0000;
            write_strobe_b <= 1'b1;
            read_strobe_b  <= 1'b1;
            data_oe        <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 8'h00;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rsp_valid <= 1'b0;
            if (accept) begin
                wr_q        <= req_write;
                wdata_q     <= req_wdata;
                address_bus <= req_addr;
                data_oe     <= req_write;
            end
            if (state == SETUP && cnt_zero) begin
                write_strobe_b <= !wr_q;
                read_strobe_b  <= wr_q;
            end
            // Read data is sampled on the same edge that releases the strobe.
            if (state == STROBE && cnt_zero) begin
                write_strobe_b <= 1'b1;
                read_strobe_b  <= 1'b1;
                if (!wr_q) begin
                    cap_q <= data_bus;
                end
            end
            if (state == HOLD && cnt_zero) begin
                data_oe   <= 1'b0;
                rsp_valid <= 1'b1;
                if (!wr_q) begin
                    rsp_rdata <= cap_q;
                end
            end
        end
    end

endmodule
